// File: rtl/dmem_responder.sv
// Memory-side responder for the processor dmem port: word RAM plus an MMIO page
// holding a console TX FIFO, an LED register and a free-running cycle counter.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] MMIO_PAGE  = 24'hFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [15:0] leds,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [7:0]            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [31:0]           r_cycle;
  logic [15:0]           r_leds;
  logic                  r_ovf;

  logic                  w_mmio;
  logic [7:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_led_wr;
  logic                  w_cyc_wr;
  logic [7:0]            w_cnt8;
  logic [31:0]           w_rd_mmio;

  assign w_mmio     = (address_dmem[31:8] == MMIO_PAGE);
  assign w_off      = address_dmem[7:0];
  assign w_idx      = address_dmem[ADDR_WIDTH-1:0];

  assign w_push_req = wren && w_mmio && (w_off == 8'h00);
  assign w_ovf_clr  = wren && w_mmio && (w_off == 8'h01) && data[0];
  assign w_led_wr   = wren && w_mmio && (w_off == 8'h02);
  assign w_cyc_wr   = wren && w_mmio && (w_off == 8'h03);

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = console_valid && console_ready;
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_cnt8     = 8'(r_count);

  always_comb begin
    w_rd_mmio = 32'b0;
    case (w_off)
      8'h01:   w_rd_mmio = {23'b0, r_ovf, w_cnt8};
      8'h02:   w_rd_mmio = {16'b0, r_leds};
      8'h03:   w_rd_mmio = r_cycle;
      default: w_rd_mmio = 32'b0;
    endcase
  end

  // RAM contents survive reset, so storage lives in unreset blocks.
  always_ff @(posedge clock) begin
    if (wren && !w_mmio) r_mem[w_idx] <= data;
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem   <= 32'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cycle  <= 32'b0;
      r_leds   <= 16'b0;
      r_ovf    <= 1'b0;
    end else begin
      q_dmem <= w_mmio ? w_rd_mmio : r_mem[w_idx];
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_cycle <= w_cyc_wr ? data : r_cycle + 32'd1;
      if (w_led_wr) r_leds <= data[15:0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign console_data  = r_fifo[r_rd_ptr];
  assign console_valid = (r_count != '0);
  assign leds          = r_leds;
  assign tx_overflow   = r_ovf;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

  localparam logic [31:0] MM = 32'hFFFF_FF00;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic [15:0] leds;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [4096];
  bit          m_known [4096];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [15:0] m_leds;
  logic [31:0] m_cyc;

  dmem_responder dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .console_data(console_data),
    .console_valid(console_valid), .console_ready(console_ready),
    .leds(leds), .tx_overflow(tx_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    address_dmem = a;
    data         = d;
    wren         = we;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_leds = 16'h0;
    m_cyc  = 32'h0;
  endtask

  // Predict the edge from the driven inputs, advance the model, then compare.
  task automatic tick();
    logic [31:0] a;
    logic [31:0] exp;
    bit          known;
    bit          pop;
    bit          mm;
    bit          ovf_set;
    int          n;
    a       = address_dmem;
    mm      = (a[31:8] == 24'hFFFFFF);
    n       = m_q.size();
    known   = 1'b1;
    exp     = 32'h0;
    ovf_set = 1'b0;
    if (mm) begin
      case (a[7:0])
        8'h01:   exp = {23'b0, m_ovf, n[7:0]};
        8'h02:   exp = {16'b0, m_leds};
        8'h03:   exp = m_cyc;
        default: exp = 32'h0;
      endcase
    end else begin
      known = m_known[a[11:0]];
      exp   = m_mem[a[11:0]];
    end
    pop = (n != 0) && console_ready;
    if (pop) void'(m_q.pop_front());
    if (wren && mm && a[7:0] == 8'h00) begin
      if (n < 8 || pop) m_q.push_back(data[7:0]);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (wren && mm && a[7:0] == 8'h01 && data[0]) m_ovf = 1'b0;
    m_cyc = (wren && mm && a[7:0] == 8'h03) ? data : m_cyc + 32'd1;
    if (wren && mm && a[7:0] == 8'h02) m_leds = data[15:0];
    if (wren && !mm) begin
      m_mem[a[11:0]]   = data;
      m_known[a[11:0]] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (known) chk("q_dmem", q_dmem, exp);
    chk("valid", {31'b0, console_valid}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) chk("cdata", {24'b0, console_data}, {24'b0, m_q[0]});
    chk("leds", {16'b0, leds}, {16'b0, m_leds});
    chk("ovf", {31'b0, tx_overflow}, {31'b0, m_ovf});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
    model_reset();
    reset = 1'b0;
    console_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #12;
    chk("rst_q", q_dmem, 32'h0);
    chk("rst_valid", {31'b0, console_valid}, 32'h0);
    chk("rst_leds", {16'b0, leds}, 32'h0);
    chk("rst_ovf", {31'b0, tx_overflow}, 32'h0);
    #1 reset = 1'b1;
    drive(MM | 32'h4, 32'h0, 1'b0); tick();

    // RAM write/read and aliasing
    drive(32'h10, 32'hDEADBEEF, 1'b1); tick();
    drive(32'h10, 32'h0, 1'b0); tick();
    chk("t1_rd", q_dmem, 32'hDEADBEEF);
    drive(32'h1010, 32'h0, 1'b0); tick();
    chk("t1_alias", q_dmem, 32'hDEADBEEF);

    // read-first on same-index write
    drive(32'h5, 32'h1, 1'b1); tick();
    drive(32'h5, 32'h2, 1'b1); tick();
    chk("t2_old", q_dmem, 32'h1);
    drive(32'h5, 32'h0, 1'b0); tick();
    chk("t2_new", q_dmem, 32'h2);

    // basic FIFO
    drive(MM, 32'h41, 1'b1); tick();
    drive(MM, 32'h42, 1'b1); tick();
    chk("t3_valid", {31'b0, console_valid}, 32'h1);
    chk("t3_head", {24'b0, console_data}, 32'h41);
    drive(MM | 32'h1, 32'h0, 1'b0); tick();
    chk("t3_cnt2", q_dmem, 32'h2);
    console_ready = 1'b1;
    drive(MM | 32'h4, 32'h0, 1'b0); tick();
    chk("t3_head2", {24'b0, console_data}, 32'h42);
    tick();
    chk("t3_empty", {31'b0, console_valid}, 32'h0);
    console_ready = 1'b0;
    drive(MM | 32'h1, 32'h0, 1'b0); tick();
    chk("t3_cnt0", q_dmem, 32'h0);

    // overflow, full push+pop, clear
    for (int i = 0; i < 9; i++) begin
      drive(MM, 32'h50 + i, 1'b1); tick();
    end
    chk("t4_ovf", {31'b0, tx_overflow}, 32'h1);
    drive(MM | 32'h1, 32'h0, 1'b0); tick();
    chk("t4_st", q_dmem, 32'h108);
    console_ready = 1'b1;
    drive(MM, 32'h77, 1'b1); tick();
    console_ready = 1'b0;
    drive(MM | 32'h1, 32'h0, 1'b0); tick();
    chk("t4_st2", q_dmem, 32'h108);
    chk("t4_head", {24'b0, console_data}, 32'h51);
    drive(MM | 32'h1, 32'h1, 1'b1); tick();
    chk("t4_clr", {31'b0, tx_overflow}, 32'h0);
    console_ready = 1'b1;
    drive(MM | 32'h4, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_drained", {31'b0, console_valid}, 32'h0);
    console_ready = 1'b0;

    // counter wrap and LED
    drive(MM | 32'h3, 32'hFFFFFFFE, 1'b1); tick();
    drive(MM | 32'h4, 32'h0, 1'b0); tick();
    drive(MM | 32'h3, 32'h0, 1'b0); tick();
    chk("t5_ff", q_dmem, 32'hFFFFFFFF);
    tick();
    chk("t5_wrap", q_dmem, 32'h0);
    drive(MM | 32'h2, 32'h1234ABCD, 1'b1); tick();
    chk("t5_leds", {16'b0, leds}, 32'h0000ABCD);
    drive(MM | 32'h2, 32'h0, 1'b0); tick();
    chk("t5_rdled", q_dmem, 32'h0000ABCD);

    // async reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(MM, 32'h61 + i, 1'b1); tick();
    end
    drive(MM | 32'h2, 32'hFFFF, 1'b1); tick();
    chk("t6_pre_leds", {16'b0, leds}, 32'hFFFF);
    drive(MM | 32'h4, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_q", q_dmem, 32'h0);
    chk("t6_valid", {31'b0, console_valid}, 32'h0);
    chk("t6_leds", {16'b0, leds}, 32'h0);
    chk("t6_ovf", {31'b0, tx_overflow}, 32'h0);
    model_reset();
    #2 reset = 1'b1;
    drive(32'h10, 32'h0, 1'b0); tick();
    chk("t6_ram", q_dmem, 32'hDEADBEEF);
    drive(MM | 32'h3, 32'h0, 1'b0); tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 2) == 0) a = MM | 32'($urandom_range(0, 5));
      else a = ($urandom & 32'h7FFF_F000) | 32'($urandom_range(0, 31));
      console_ready = ($urandom_range(0, 2) == 0);
      drive(a, $urandom, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
